// File: rtl/gray_bcd_counter.sv
// Multi-digit BCD up/down counter with Gray-BCD digit outputs.
// Provides clear, parallel load, terminal count and a wrap pulse for cascading.
module gray_bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  input  logic                  step,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   gray,
  output logic                  tc,
  output logic                  wrap,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_bcd;
  logic         r_step_q;
  logic         r_wrap;
  logic         r_err;

  logic         w_rise;
  logic         w_count;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_ld;
  logic         w_ld_bad;
  logic         w_all9;
  logic         w_all0;
  logic         w_cy_up;
  logic         w_cy_dn;
  logic [3:0]   w_d;
  logic [3:0]   w_ldd;
  logic [W-1:0] w_gray;

  // Gray-BCD code for one decade digit; adjacent values differ in one bit.
  function automatic logic [3:0] f_gray(input logic [3:0] v);
    logic [3:0] g;
    case (v)
      4'd0:    g = 4'b0000;
      4'd1:    g = 4'b0001;
      4'd2:    g = 4'b0011;
      4'd3:    g = 4'b0010;
      4'd4:    g = 4'b0110;
      4'd5:    g = 4'b0111;
      4'd6:    g = 4'b0101;
      4'd7:    g = 4'b0100;
      4'd8:    g = 4'b1100;
      4'd9:    g = 4'b1000;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  assign w_rise  = step & ~r_step_q;
  assign w_count = en & w_rise;

  // Next-count candidates: ripple carry (up) and borrow (down) across digits.
  always_comb begin
    w_inc   = r_bcd;
    w_dec   = r_bcd;
    w_cy_up = 1'b1;
    w_cy_dn = 1'b1;
    w_all9  = 1'b1;
    w_all0  = 1'b1;
    w_d     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_bcd[4*i +: 4];
      if (w_d != 4'd9)
        w_all9 = 1'b0;
      if (w_d != 4'd0)
        w_all0 = 1'b0;
      if (w_cy_up) begin
        if (w_d == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = w_d + 4'd1;
          w_cy_up = 1'b0;
        end
      end
      if (w_cy_dn) begin
        if (w_d == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = w_d - 4'd1;
          w_cy_dn = 1'b0;
        end
      end
    end
  end

  // Load value sanitising: any non-decimal digit becomes 0 and flags an error.
  always_comb begin
    w_ld     = '0;
    w_ld_bad = 1'b0;
    w_ldd    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_ldd = load_val[4*i +: 4];
      if (w_ldd > 4'd9) begin
        w_ld[4*i +: 4] = 4'd0;
        w_ld_bad = 1'b1;
      end else begin
        w_ld[4*i +: 4] = w_ldd;
      end
    end
  end

  // Gray outputs are a pure function of the count register.
  always_comb begin
    w_gray = '0;
    for (int i = 0; i < DIGITS; i++)
      w_gray[4*i +: 4] = f_gray(r_bcd[4*i +: 4]);
  end

  // Count state update with priority rst > clr > load > count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd    <= '0;
      r_step_q <= 1'b1;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_step_q <= step;
      r_wrap   <= 1'b0;
      if (clr) begin
        r_bcd <= '0;
        r_err <= 1'b0;
      end else if (load) begin
        r_bcd <= w_ld;
        if (w_ld_bad)
          r_err <= 1'b1;
      end else if (w_count) begin
        if (up) begin
          r_bcd  <= w_inc;
          r_wrap <= w_all9;
        end else begin
          r_bcd  <= w_dec;
          r_wrap <= w_all0;
        end
      end
    end
  end

  assign bcd  = r_bcd;
  assign gray = w_gray;
  assign tc   = up ? w_all9 : w_all0;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
